// File: rtl/i2c_reg_slave_sync_if.sv
// Bus bundle between the I2C target, the top-level pin mux and the
// configuration register bank. The slave modport is the target's view.
interface i2c_reg_slave_sync_if #(
   parameter int PTR_W = 8
);
   logic             scl_in;
   logic             sda_in;
   logic             sda_oe;
   logic [PTR_W-1:0] reg_addr;
   logic [7:0]       reg_wdata;
   logic             reg_wr_en;
   logic [7:0]       reg_rdata;
   logic             reg_rd_en;
   logic             busy;

   modport slave (
      input  scl_in, sda_in, reg_rdata,
      output sda_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy
   );

   modport master (
      output scl_in, sda_in, reg_rdata,
      input  sda_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy
   );
endinterface

// File: rtl/i2c_reg_slave_sync.sv
// Oversampling I2C register target. SCL and SDA are synchronised into the
// clk domain and edge-detected; SCL is never used as a clock. Exposes a
// NUM_REGS x 8-bit register window with pointer auto-increment.
module i2c_reg_slave_sync #(
   parameter logic [6:0] DEV_ADDR    = 7'h42,
   parameter int         NUM_REGS    = 16,
   parameter int         PTR_W       = 8,
   parameter int         SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   i2c_reg_slave_sync_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK,
      IGNORE
   } state_t;

   localparam logic [PTR_W-1:0] LAST_REG = PTR_W'(NUM_REGS - 1);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;

   state_t                 state;
   logic [1:0]             phase;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   rw;
   logic                   sda_oe_q;
   logic [PTR_W-1:0]       reg_addr_q;
   logic [7:0]             reg_wdata_q;
   logic                   reg_wr_en_q;
   logic                   reg_rd_en_q;
   logic                   busy_q;

   logic [7:0]             byte_in;
   logic                   last_bit;
   logic                   ptr_in_range;
   logic [PTR_W-1:0]       addr_next;

   // Synchronise the raw pins and keep one history flop for edge detection;
   // flops reset high because an idle bus is pulled up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

   assign byte_in      = {shreg[6:0], sda_s};
   assign last_bit     = (bit_cnt == 3'd7);
   assign ptr_in_range = ({24'd0, byte_in} < $unsigned(NUM_REGS));
   assign addr_next    = (reg_addr_q == LAST_REG) ? '0 : reg_addr_q + PTR_W'(1);

   // Protocol FSM: bits are sampled on SCL rise, SDA is only changed after an
   // SCL fall; START/STOP override any bit event seen in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase       <= 2'd0;
         bit_cnt     <= 3'd0;
         shreg       <= 8'h00;
         rw          <= 1'b0;
         sda_oe_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'h00;
         reg_wr_en_q <= 1'b0;
         reg_rd_en_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         reg_wr_en_q <= 1'b0;
         reg_rd_en_q <= 1'b0;
         if (stop_det) begin
            state    <= IDLE;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else if (start_det) begin
            state    <= ADDR;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            sda_oe_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  sda_oe_q <= 1'b0;
               end

               ADDR: begin
                  if (scl_rise) begin
                     shreg   <= byte_in;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        rw    <= sda_s;
                        phase <= 2'd0;
                        if (byte_in[7:1] == DEV_ADDR) begin
                           state  <= ADDR_ACK;
                           busy_q <= 1'b1;
                        end else begin
                           state  <= IGNORE;
                           busy_q <= 1'b0;
                        end
                     end
                  end
               end

               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (phase == 2'd0) begin
                        sda_oe_q <= 1'b1;
                        phase    <= 2'd1;
                     end else begin
                        phase   <= 2'd0;
                        bit_cnt <= 3'd0;
                        if (rw) begin
                           reg_rd_en_q <= 1'b1;
                           shreg       <= {bus.reg_rdata[6:0], 1'b0};
                           sda_oe_q    <= ~bus.reg_rdata[7];
                           state       <= RDATA;
                        end else begin
                           sda_oe_q <= 1'b0;
                           state    <= PTR;
                        end
                     end
                  end
               end

               PTR: begin
                  if (scl_rise) begin
                     shreg   <= byte_in;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        phase <= 2'd0;
                        if (ptr_in_range) begin
                           reg_addr_q <= PTR_W'(byte_in);
                           state      <= PTR_ACK;
                        end else begin
                           state <= IGNORE;
                        end
                     end
                  end
               end

               PTR_ACK: begin
                  if (scl_fall) begin
                     if (phase == 2'd0) begin
                        sda_oe_q <= 1'b1;
                        phase    <= 2'd1;
                     end else begin
                        sda_oe_q <= 1'b0;
                        phase    <= 2'd0;
                        bit_cnt  <= 3'd0;
                        state    <= WDATA;
                     end
                  end
               end

               WDATA: begin
                  if (scl_rise) begin
                     shreg   <= byte_in;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        reg_wdata_q <= byte_in;
                        reg_wr_en_q <= 1'b1;
                        phase       <= 2'd0;
                        state       <= WDATA_ACK;
                     end
                  end
               end

               WDATA_ACK: begin
                  if (scl_fall) begin
                     if (phase == 2'd0) begin
                        sda_oe_q <= 1'b1;
                        phase    <= 2'd1;
                     end else begin
                        sda_oe_q   <= 1'b0;
                        phase      <= 2'd0;
                        bit_cnt    <= 3'd0;
                        reg_addr_q <= addr_next;
                        state      <= WDATA;
                     end
                  end
               end

               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (last_bit) begin
                        phase <= 2'd0;
                        state <= RACK;
                     end
                  end else if (scl_fall) begin
                     sda_oe_q <= ~shreg[7];
                     shreg    <= {shreg[6:0], 1'b0};
                  end
               end

               RACK: begin
                  case (phase)
                     2'd0: begin
                        if (scl_fall) begin
                           sda_oe_q <= 1'b0;
                           phase    <= 2'd1;
                        end
                     end
                     2'd1: begin
                        if (scl_rise) begin
                           if (!sda_s) begin
                              reg_addr_q <= addr_next;
                              phase      <= 2'd2;
                           end else begin
                              phase <= 2'd0;
                              state <= IGNORE;
                           end
                        end
                     end
                     default: begin
                        if (scl_fall) begin
                           reg_rd_en_q <= 1'b1;
                           shreg       <= {bus.reg_rdata[6:0], 1'b0};
                           sda_oe_q    <= ~bus.reg_rdata[7];
                           bit_cnt     <= 3'd0;
                           phase       <= 2'd0;
                           state       <= RDATA;
                        end
                     end
                  endcase
               end

               IGNORE: begin
                  sda_oe_q <= 1'b0;
               end

               default: begin
                  sda_oe_q <= 1'b0;
                  state    <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.sda_oe    = sda_oe_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_wr_en = reg_wr_en_q;
   assign bus.reg_rd_en = reg_rd_en_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave_sync.sv
// Bench for i2c_reg_slave_sync: a bit-banged I2C master drives the bus,
// expected register strobes are queued and a monitor checks them as they occur.
module tb_i2c_reg_slave_sync;

   localparam int Q = 5;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_exp_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         wr_seen  = 0;
   int         rd_seen  = 0;
   int         oe_seen  = 0;

   wr_exp_t    exp_wr[$];
   logic [7:0] exp_rd[$];
   wr_exp_t    wr_pop;
   logic [7:0] rd_pop;

   logic       ack;
   logic [7:0] rx;

   i2c_reg_slave_sync_if #(.PTR_W(8)) bus ();

   assign bus.scl_in    = scl_m;
   assign bus.sda_in    = sda_m & ~bus.sda_oe;
   assign bus.reg_rdata = bus.reg_addr + 8'hA0;

   i2c_reg_slave_sync #(
      .DEV_ADDR(7'h42),
      .NUM_REGS(16),
      .PTR_W(8),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Monitor: pops the expected strobe whenever the DUT issues one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.sda_oe) oe_seen++;
         if (bus.reg_wr_en && bus.reg_rd_en) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL strobe_overlap: got wr_en=1 rd_en=1, required never both");
         end
         if (bus.reg_wr_en) begin
            wr_seen++;
            n_checks++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%02h, required no write",
                        bus.reg_addr, bus.reg_wdata);
            end else begin
               wr_pop = exp_wr.pop_front();
               if (bus.reg_addr !== wr_pop.addr || bus.reg_wdata !== wr_pop.data) begin
                  n_fail++;
                  $display("[TB] FAIL write_strobe: got addr=%0d data=0x%02h, required addr=%0d data=0x%02h",
                           bus.reg_addr, bus.reg_wdata, wr_pop.addr, wr_pop.data);
               end
            end
         end
         if (bus.reg_rd_en) begin
            rd_seen++;
            n_checks++;
            if (exp_rd.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_read: got addr=%0d, required no read", bus.reg_addr);
            end else begin
               rd_pop = exp_rd.pop_front();
               if (bus.reg_addr !== rd_pop) begin
                  n_fail++;
                  $display("[TB] FAIL read_strobe: got addr=%0d, required addr=%0d",
                           bus.reg_addr, rd_pop);
               end
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, output logic s);
      wait_clk(Q);
      sda_m = b;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      s = bus.sda_in;
      wait_clk(Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      sda_m = 1'b0;
      wait_clk(2 * Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      sda_m = 1'b1;
      wait_clk(2 * Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      logic s;
      for (int i = 7; i > 7 - n; i--) send_bit(b[i], s);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic got_ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, s);
      got_ack = ~s;
   endtask

   task automatic read_byte(input logic give_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(~give_ack, s);
   endtask

   // Directed scenarios with hand-computed expectations.
   initial begin
      wait_clk(4);
      check_output("reset_sda_oe", 32'(bus.sda_oe), 32'd0);
      check_output("reset_reg_addr", 32'(bus.reg_addr), 32'd0);
      check_output("reset_reg_wdata", 32'(bus.reg_wdata), 32'd0);
      check_output("reset_wr_en", 32'(bus.reg_wr_en), 32'd0);
      check_output("reset_rd_en", 32'(bus.reg_rd_en), 32'd0);
      check_output("reset_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      wait_clk(10);

      $display("[TB] single write");
      i2c_start();
      write_byte(8'h84, ack);
      check_output("wr_addr_ack", 32'(ack), 32'd1);
      check_output("wr_busy_set", 32'(bus.busy), 32'd1);
      write_byte(8'h03, ack);
      check_output("wr_ptr_ack", 32'(ack), 32'd1);
      check_output("wr_ptr_loaded", 32'(bus.reg_addr), 32'd3);
      exp_wr.push_back('{addr: 8'h03, data: 8'h5A});
      write_byte(8'h5A, ack);
      check_output("wr_data_ack", 32'(ack), 32'd1);
      check_output("wr_busy_before_stop", 32'(bus.busy), 32'd1);
      i2c_stop();
      wait_clk(5);
      check_output("wr_busy_after_stop", 32'(bus.busy), 32'd0);
      check_output("wr_count", 32'(wr_seen), 32'd1);
      check_output("wr_addr_incr", 32'(bus.reg_addr), 32'd4);

      $display("[TB] wrong address");
      oe_seen = 0;
      i2c_start();
      write_byte(8'h86, ack);
      check_output("wrong_addr_nack", 32'(ack), 32'd0);
      check_output("wrong_addr_busy", 32'(bus.busy), 32'd0);
      write_byte(8'h00, ack);
      check_output("wrong_data_nack", 32'(ack), 32'd0);
      i2c_stop();
      wait_clk(5);
      check_output("wrong_sda_oe_never", 32'(oe_seen), 32'd0);
      check_output("wrong_no_write", 32'(wr_seen), 32'd1);
      check_output("wrong_no_read", 32'(rd_seen), 32'd0);

      $display("[TB] burst read with wrap");
      i2c_start();
      write_byte(8'h84, ack);
      check_output("rd_waddr_ack", 32'(ack), 32'd1);
      write_byte(8'h0F, ack);
      check_output("rd_ptr_ack", 32'(ack), 32'd1);
      check_output("rd_ptr_loaded", 32'(bus.reg_addr), 32'd15);
      i2c_start();
      exp_rd.push_back(8'd15);
      write_byte(8'h85, ack);
      check_output("rd_raddr_ack", 32'(ack), 32'd1);
      check_output("rd_busy_kept", 32'(bus.busy), 32'd1);
      exp_rd.push_back(8'd0);
      read_byte(1'b1, rx);
      check_output("rd_byte0", 32'(rx), 32'hAF);
      exp_rd.push_back(8'd1);
      read_byte(1'b1, rx);
      check_output("rd_byte1", 32'(rx), 32'hA0);
      read_byte(1'b0, rx);
      check_output("rd_byte2", 32'(rx), 32'hA1);
      wait_clk(5);
      check_output("rd_sda_released", 32'(bus.sda_oe), 32'd0);
      check_output("rd_addr_final", 32'(bus.reg_addr), 32'd1);
      i2c_stop();
      wait_clk(5);
      check_output("rd_count", 32'(rd_seen), 32'd3);
      check_output("rd_no_write", 32'(wr_seen), 32'd1);

      $display("[TB] out-of-range pointer");
      i2c_start();
      write_byte(8'h84, ack);
      check_output("oor_addr_ack", 32'(ack), 32'd1);
      write_byte(8'h20, ack);
      check_output("oor_ptr_nack", 32'(ack), 32'd0);
      write_byte(8'h11, ack);
      check_output("oor_data_nack", 32'(ack), 32'd0);
      i2c_stop();
      wait_clk(5);
      check_output("oor_addr_kept", 32'(bus.reg_addr), 32'd1);
      check_output("oor_no_write", 32'(wr_seen), 32'd1);

      $display("[TB] stop mid-byte");
      i2c_start();
      write_byte(8'h84, ack);
      check_output("mid_addr_ack", 32'(ack), 32'd1);
      write_byte(8'h01, ack);
      check_output("mid_ptr_ack", 32'(ack), 32'd1);
      send_bits(8'hFF, 4);
      i2c_stop();
      wait_clk(5);
      check_output("mid_no_write", 32'(wr_seen), 32'd1);
      check_output("mid_sda_oe", 32'(bus.sda_oe), 32'd0);
      check_output("mid_busy", 32'(bus.busy), 32'd0);

      $display("[TB] reset mid-transaction");
      i2c_start();
      send_bits(8'h84, 8);
      wait_clk(Q);
      check_output("rst_ack_driving", 32'(bus.sda_oe), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("rst_sda_oe_async", 32'(bus.sda_oe), 32'd0);
      check_output("rst_busy", 32'(bus.busy), 32'd0);
      check_output("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
      check_output("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(10);
      i2c_start();
      write_byte(8'h84, ack);
      check_output("post_rst_addr_ack", 32'(ack), 32'd1);
      write_byte(8'h07, ack);
      check_output("post_rst_ptr_ack", 32'(ack), 32'd1);
      exp_wr.push_back('{addr: 8'h07, data: 8'hC3});
      write_byte(8'hC3, ack);
      check_output("post_rst_data_ack", 32'(ack), 32'd1);
      i2c_stop();
      wait_clk(5);
      check_output("post_rst_wr_count", 32'(wr_seen), 32'd2);
      check_output("post_rst_addr_incr", 32'(bus.reg_addr), 32'd8);
      check_output("post_rst_busy", 32'(bus.busy), 32'd0);

      check_output("pending_writes", 32'(exp_wr.size()), 32'd0);
      check_output("pending_reads", 32'(exp_rd.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_reg_slave_sync.md
Name: i2c_reg_slave_sync

Overview:
- Second-generation I2C target for the design's programming port. It oversamples SCL/SDA in the `clk` domain; SCL is not used as a clock.
- Exposes a parametrised register window: 8-bit data, NUM_REGS registers, configurable 7-bit device address.
- Supports writes, reads, auto-increment bursts, repeated START, and a NACK when the register index is out of range.
- Sits between the top-level pin mux (SCL/SDA inputs, open-drain SDA enable) and the design's configuration register bank.

Parameters:
- DEV_ADDR, 7'h42, 7-bit I2C target address.
- NUM_REGS, 16, number of addressable registers (2..256).
- PTR_W, 8, register pointer width; must satisfy 2^PTR_W >= NUM_REGS.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk  input  1  system clock; must be >= 16x SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  raw SCL pin.
- sda_in  input  1  raw SDA pin.
- sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
- reg_addr  output  PTR_W  current register pointer.
- reg_wdata  output  8  write data, valid while reg_wr_en=1.
- reg_wr_en  output  1  single-cycle write strobe.
- reg_rdata  input  8  read data for reg_addr; must be combinational or stable by the next clk.
- reg_rd_en  output  1  single-cycle strobe when a byte is loaded for transmit.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- **Reset values:** sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, busy=0, state=IDLE. The synchroniser flops reset to 1 (bus idle high).
- **Sampling:** scl_in/sda_in pass through SYNC_STAGES flops plus one history flop. Edges are detected SYNC_STAGES+1 clk after the pin change.
- **START:** SDA fall while SCL high. **STOP:** SDA rise while SCL high. Both take priority over bit events in the same cycle.
- **Bit timing:** data is sampled on SCL rise. sda_oe changes only in the clk cycle after an SCL fall is detected.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- IDLE: START -> ADDR with bit counter 0.
- ADDR: shift 8 bits MSB-first.
  - If the upper 7 bits match DEV_ADDR, go to ADDR_ACK and drive sda_oe=1 for the 9th SCL clock.
  - If they do not match, go to IGNORE and leave sda_oe=0.
- ADDR_ACK, R/W=0: -> PTR.
- ADDR_ACK, R/W=1: pulse reg_rd_en, load the shifter from reg_rdata at reg_addr, -> RDATA. The MSB is driven on the same SCL fall that releases the ACK.
- PTR: 8 bits; the pointer is loaded after the 8th bit.
  - value < NUM_REGS: reg_addr <= value, ACK, -> WDATA.
  - value >= NUM_REGS: NACK (sda_oe stays 0), reg_addr unchanged, -> IGNORE.
- WDATA: after the 8th bit is sampled, reg_wdata <= byte and reg_wr_en pulses for exactly 1 clk.
  - Then ACK, reg_addr++ (wrapping NUM_REGS-1 -> 0), return to WDATA.
- RDATA: send 8 bits, driving sda_oe = ~bit, then release for RACK.
  - Master ACK (SDA=0 at the rise): reg_addr++ (wrap), pulse reg_rd_en, reload the shifter, -> RDATA.
  - Master NACK: -> IGNORE.
- IGNORE: sda_oe=0; wait for START or STOP.
- Repeated START in any state: -> ADDR with counter cleared, sda_oe released, reg_addr kept. This is how the write-pointer-then-read sequence works.
- STOP in any state: -> IDLE, sda_oe=0, busy=0. A partial byte is discarded and no reg_wr_en is issued.
- busy: set on the address-match ACK; cleared on STOP or on a START that does not match.
- reg_wr_en and reg_rd_en are never high in the same cycle.

Test Plan:
- **Single write:** START, 0x84, 0x03, 0x5A, STOP -> ACK on all three bytes; one reg_wr_en pulse with reg_addr=3 and reg_wdata=0x5A; busy falls at STOP.
- **Wrong address:** START, 0x86, 0x00, STOP -> sda_oe never asserted; no strobes; busy stays 0.
- **Burst read with wrap:** write pointer 0x0F, then repeated START, 0x85, read 3 bytes (ACK, ACK, NACK) with reg_rdata=reg_addr+0xA0.
  - Transmitted bytes: 0xAF, 0xA0, 0xA1.
  - reg_addr sequence: 15, 0, 1.
  - SDA released after the NACK.
- **Out-of-range pointer:** START, 0x84, 0x20 with NUM_REGS=16 -> NACK on the 9th clock; following data bytes produce no reg_wr_en.
- **STOP mid-byte:** START, 0x84, 0x01, 4 bits of 0xFF, STOP -> no reg_wr_en; state IDLE; sda_oe=0.
- **Reset mid-transaction:** rst_n low during an ACK drive -> sda_oe=0 immediately (asynchronous); all outputs at reset values; the next full write sequence completes normally.
